// File: rtl/burst_rx.sv
// Carrier burst receiver: recovers the envelope of a square-wave carrier burst,
// qualifies each rising edge by its period and reports start/end/pulse count.
module burst_rx #(
    parameter int CLKS_PER_HALF_PERIOD = 5,
    parameter int PERIOD_TOL           = 1,
    parameter int MIN_PULSES           = 4,
    parameter int TIMEOUT_CYCLES       = 202,
    parameter int COUNT_WIDTH          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in,
    output logic                   burst_active,
    output logic                   burst_start,
    output logic                   burst_end,
    output logic [COUNT_WIDTH-1:0] burst_pulses,
    output logic                   period_err
);

    localparam int P0 = 2 * CLKS_PER_HALF_PERIOD;
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] LP_LO  = GW'((P0 > PERIOD_TOL) ? (P0 - PERIOD_TOL) : 0);
    localparam logic [GW-1:0] LP_HI  = GW'(P0 + PERIOD_TOL);
    localparam logic [GW-1:0] LP_TMO = GW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] LP_ONE = GW'(1);
    localparam logic [COUNT_WIDTH-1:0] LP_CMAX = '1;
    localparam logic [COUNT_WIDTH-1:0] LP_MIN  = COUNT_WIDTH'(MIN_PULSES);
    localparam logic [COUNT_WIDTH-1:0] LP_C1   = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

    state_t                 r_state;
    logic                   r_s1, r_s2, r_s3;
    logic [GW-1:0]          r_gap;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_active, r_start, r_end, r_err;
    logic [COUNT_WIDTH-1:0] r_pulses;

    logic                   w_rise;
    logic                   w_valid;
    logic                   w_timeout;
    logic [COUNT_WIDTH-1:0] w_cnt_inc;

    // r_gap holds the clock count since the last rise, i.e. the period at the next rise
    assign w_rise    = r_s2 & ~r_s3;
    assign w_valid   = (r_gap >= LP_LO) && (r_gap <= LP_HI);
    assign w_timeout = (r_gap == LP_TMO) && !w_rise;
    assign w_cnt_inc = (r_cnt == LP_CMAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_gap    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_start  <= 1'b0;
            r_end    <= 1'b0;
            r_err    <= 1'b0;
            r_pulses <= '0;
        end else begin
            r_s1    <= in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_err   <= 1'b0;

            if (w_rise)
                r_gap <= LP_ONE;
            else if (r_gap != LP_TMO)
                r_gap <= r_gap + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_cnt   <= LP_C1;
                        r_state <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (w_rise) begin
                        if (w_valid) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LP_MIN) begin
                                r_start  <= 1'b1;
                                r_active <= 1'b1;
                                r_state  <= S_LOCK;
                            end
                        end else begin
                            // an off-period edge restarts acquisition from itself
                            r_cnt <= LP_C1;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOCK: begin
                    if (w_rise) begin
                        if (w_valid)
                            r_cnt <= w_cnt_inc;
                        else
                            r_err <= 1'b1;
                    end else if (w_timeout) begin
                        r_end    <= 1'b1;
                        r_pulses <= r_cnt;
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign burst_active = r_active;
    assign burst_start  = r_start;
    assign burst_end    = r_end;
    assign burst_pulses = r_pulses;
    assign period_err   = r_err;

endmodule

// File: tb/tb_burst_rx.sv
// Scoreboard bench for burst_rx: stimulus queues expected strobes with their
// cycle and pulse count; a negedge monitor pops and compares each DUT strobe.
module tb_burst_rx;

    localparam int K_START = 1;
    localparam int K_ERR   = 2;
    localparam int K_END   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in  = 1'b0;
    logic       burst_active, burst_start, burst_end, period_err;
    logic [7:0] burst_pulses;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int kind;
        int cyc;
        int pulses;
    } ev_t;
    ev_t q[$];

    burst_rx dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .burst_active(burst_active),
        .burst_start (burst_start),
        .burst_end   (burst_end),
        .burst_pulses(burst_pulses),
        .period_err  (period_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input int pulses);
        ev_t e;
        e.kind   = kind;
        e.cyc    = c;
        e.pulses = pulses;
        q.push_back(e);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_strobe_kind", kind, 0);
        end else begin
            e = q.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_cycle", cyc, e.cyc);
            if (kind == K_END) begin
                chk("burst_pulses", int'(burst_pulses), e.pulses);
                chk("active_after_end", int'(burst_active), 0);
            end
            if (kind == K_START)
                chk("active_at_start", int'(burst_active), 1);
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the queue
    always @(negedge clk) begin
        if (burst_start) handle(K_START);
        if (period_err)  handle(K_ERR);
        if (burst_end)   handle(K_END);
    end

    // One carrier pulse: h clocks high, l clocks low; k is the posedge that first samples it high
    task automatic pulse(input int h, input int l, input int ev, output int k);
        in = 1'b1;
        k  = cyc + 1;
        if (ev != 0) expect_ev(ev, k + 2, 0);
        repeat (h) @(negedge clk);
        in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic idle(input int n);
        in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk({tag, "_active"}, int'(burst_active), 0);
        chk({tag, "_start"},  int'(burst_start), 0);
        chk({tag, "_end"},    int'(burst_end), 0);
        chk({tag, "_err"},    int'(period_err), 0);
        chk({tag, "_pulses"}, int'(burst_pulses), 0);
        rst = 1'b0;
    endtask

    task automatic chk_drained(input string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int hs[4];
        int ls[4];
        int lockp[4];
        hs    = '{4, 5, 5, 6};
        ls    = '{4, 4, 6, 6};
        lockp = '{0, 1, 1, 0};

        @(negedge clk);
        do_reset("reset");

        // Test 1: 13 nominal pulses
        for (int i = 1; i <= 13; i++) begin
            pulse(5, 5, (i == 4) ? K_START : 0, k);
            if (i == 6) chk("t1_active_mid", int'(burst_active), 1);
        end
        expect_ev(K_END, k + 204, 13);
        idle(230);
        chk_drained("t1_drained");

        // Test 2: too few pulses after reset
        do_reset("t2_reset");
        for (int i = 1; i <= 3; i++) pulse(5, 5, 0, k);
        idle(230);
        chk("t2_pulses", int'(burst_pulses), 0);
        chk("t2_active", int'(burst_active), 0);
        chk_drained("t2_drained");

        // Test 3: one stretched period while locked
        for (int i = 1; i <= 6; i++) pulse(5, (i == 6) ? 9 : 5, (i == 4) ? K_START : 0, k);
        pulse(5, 5, K_ERR, k);
        for (int i = 1; i <= 4; i++) pulse(5, 5, 0, k);
        expect_ev(K_END, k + 204, 10);
        idle(230);
        chk_drained("t3_drained");

        // Test 4: period sweep 8, 9, 11, 12
        for (int p = 0; p < 4; p++) begin
            for (int i = 1; i <= 10; i++)
                pulse(hs[p], ls[p], (i == 4 && lockp[p] == 1) ? K_START : 0, k);
            if (lockp[p] == 1) expect_ev(K_END, k + 204, 10);
            idle(230);
            chk_drained("t4_drained");
        end

        // Test 5: pulse count saturation
        for (int i = 1; i <= 300; i++) pulse(5, 5, (i == 4) ? K_START : 0, k);
        expect_ev(K_END, k + 204, 255);
        idle(230);
        chk_drained("t5_drained");

        // Test 6: reset mid-burst, then a clean short burst
        for (int i = 1; i <= 8; i++) pulse(5, 5, (i == 4) ? K_START : 0, k);
        chk("t6_active_pre", int'(burst_active), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_active", int'(burst_active), 0);
        chk("t6_rst_end",    int'(burst_end), 0);
        chk("t6_rst_pulses", int'(burst_pulses), 0);
        rst = 1'b0;
        idle(230);
        chk_drained("t6_no_end");
        for (int i = 1; i <= 5; i++) pulse(5, 5, (i == 4) ? K_START : 0, k);
        expect_ev(K_END, k + 204, 5);
        idle(230);
        chk_drained("t6_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
